// File: rtl/reg_bank.sv
// Sixteen-entry register bank with parallel read-out and a handshaked debug dump engine.
// Optional macro REG_BANK_R0_ZERO_EN hardwires r0 to zero.
module reg_bank #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r4,
  output logic [WIDTH-1:0] r5,
  output logic [WIDTH-1:0] r6,
  output logic [WIDTH-1:0] r7,
  output logic [WIDTH-1:0] r8,
  output logic [WIDTH-1:0] r9,
  output logic [WIDTH-1:0] r10,
  output logic [WIDTH-1:0] r11,
  output logic [WIDTH-1:0] r12,
  output logic [WIDTH-1:0] r13,
  output logic [WIDTH-1:0] r14,
  output logic [WIDTH-1:0] r15,
  input  logic             dump_start,
  output logic             dump_busy,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [3:0]       dump_addr,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_done
);

  localparam int unsigned NREG = 16;
  localparam int unsigned AW   = 4;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  logic [WIDTH-1:0] regs [NREG];
  logic             wr_ok_c;
  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             busy_d, valid_d, done_d;

`ifdef REG_BANK_R0_ZERO_EN
  assign wr_ok_c = (wr_addr != '0);
`else
  assign wr_ok_c = 1'b1;
`endif

  // Register storage: one write port from write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && wr_ok_c) begin
      regs[wr_addr] <= wr_data;
    end
  end

`ifdef REG_BANK_R0_ZERO_EN
  assign r0 = '0;
`else
  assign r0 = regs[0];
`endif
  assign r1  = regs[1];
  assign r2  = regs[2];
  assign r3  = regs[3];
  assign r4  = regs[4];
  assign r5  = regs[5];
  assign r6  = regs[6];
  assign r7  = regs[7];
  assign r8  = regs[8];
  assign r9  = regs[9];
  assign r10 = regs[10];
  assign r11 = regs[11];
  assign r12 = regs[12];
  assign r13 = regs[13];
  assign r14 = regs[14];
  assign r15 = regs[15];

  // Dump next-state; status flags are precomputed from the next state so they leave a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          state_d = SEND;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (dump_ready) begin
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == SEND);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dump_busy  <= 1'b0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dump_busy  <= busy_d;
      dump_valid <= valid_d;
      dump_done  <= done_d;
    end
  end

  // Beat data follows the live register so a stalled beat reflects later writes.
  assign dump_addr = cnt_q;
`ifdef REG_BANK_R0_ZERO_EN
  assign dump_data = (cnt_q == '0) ? '0 : regs[cnt_q];
`else
  assign dump_data = regs[cnt_q];
`endif

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed steps plus random traffic against a behavioural model.
// Honours REG_BANK_R0_ZERO_EN the same way as the design.
module tb_reg_bank;

  localparam int unsigned WIDTH = 16;
`ifdef REG_BANK_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_en = 1'b0;
  logic [3:0]       wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             dump_start = 1'b0;
  logic             dump_ready = 1'b0;
  logic [WIDTH-1:0] r [16];
  logic             dump_busy, dump_valid, dump_done;
  logic [3:0]       dump_addr;
  logic [WIDTH-1:0] dump_data;

  reg_bank #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .r0(r[0]), .r1(r[1]), .r2(r[2]), .r3(r[3]), .r4(r[4]), .r5(r[5]), .r6(r[6]), .r7(r[7]),
    .r8(r[8]), .r9(r[9]), .r10(r[10]), .r11(r[11]), .r12(r[12]), .r13(r[13]), .r14(r[14]),
    .r15(r[15]),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Model: register contents, dump phase (0 idle, 1 sending, 2 done), next expected beat index.
  logic [WIDTH-1:0] mregs [16];
  int phase = 0;
  int exp_addr = 0;
  int done_seen = 0;
  int beats = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("dump_valid", 32'(dump_valid), 32'(phase == 1));
    check("dump_busy", 32'(dump_busy), 32'(phase != 0));
    check("dump_done", 32'(dump_done), 32'(phase == 2));
    if (phase == 1) begin
      check("dump_addr", 32'(dump_addr), 32'(exp_addr));
      check("dump_data", 32'(dump_data), 32'(mregs[exp_addr]));
    end
    for (int i = 0; i < 16; i++) begin
      check($sformatf("r%0d", i), 32'(r[i]), 32'(mregs[i]));
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    phase = 0;
    exp_addr = 0;
  endtask

  // One clock: score any beat handed over on this edge, advance the model, then check after the edge.
  task automatic cycle();
    bit acc;
    acc = (phase == 1) && dump_ready;
    if (acc) begin
      check("beat_addr", 32'(dump_addr), 32'(exp_addr));
      check("beat_data", 32'(dump_data), 32'(mregs[exp_addr]));
      beats++;
    end
    if (phase == 0) begin
      if (dump_start) begin
        phase = 1;
        exp_addr = 0;
      end
    end else if (phase == 1) begin
      if (acc) begin
        if (exp_addr == 15) phase = 2;
        else exp_addr++;
      end
    end else begin
      phase = 0;
    end
    if (wr_en && !(R0_ZERO && wr_addr == 4'd0)) mregs[wr_addr] = wr_data;
    @(posedge clk);
    #1;
    if (phase == 2) done_seen++;
    check_outputs();
  endtask

  // Reset asserted between edges; everything must clear before the next edge.
  task automatic mid_reset();
    #3;
    reset = 1'b1;
    #1;
    model_clear();
    check_outputs();
    check("rst_dump_addr", 32'(dump_addr), 32'd0);
    check("rst_dump_data", 32'(dump_data), 32'd0);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_addr(input int target);
    int n = 0;
    while (!(phase == 1 && exp_addr == target) && n < 40) begin
      cycle();
      n++;
    end
    check($sformatf("reach_addr_%0d", target), 32'(phase == 1 && exp_addr == target), 32'd1);
  endtask

  initial begin
    int busy_cnt;
    int n;
    model_clear();

    // Power-on reset
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("por_dump_addr", 32'(dump_addr), 32'd0);
    check("por_dump_data", 32'(dump_data), 32'd0);
    reset = 1'b0;

    // Mid-cycle reset with r5 loaded
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
    cycle();
    wr_en = 1'b0;
    check("r5_loaded", 32'(r[5]), 32'h1234);
    mid_reset();
    check("r5_cleared", 32'(r[5]), 32'h0);

    // Write every register
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'hA000 + 16'(i);
      cycle();
      check("write_all", 32'(r[i]), (R0_ZERO && i == 0) ? 32'h0 : 32'hA000 + 32'(i));
    end
    wr_en = 1'b0;
    cycle();

    // Full dump with ready held high
    dump_ready = 1'b1;
    dump_start = 1'b1;
    done_seen = 0; beats = 0;
    cycle();
    dump_start = 1'b0;
    busy_cnt = dump_busy ? 1 : 0;
    n = 0;
    while (phase != 0 && n < 40) begin
      cycle();
      if (dump_busy) busy_cnt++;
      n++;
    end
    check("full_beats", 32'(beats), 32'd16);
    check("full_done_pulses", 32'(done_seen), 32'd1);
    check("full_busy_cycles", 32'(busy_cnt), 32'd17);

    // Collision at addr 4, backpressure at addr 7, ignored start at 9, reset at 12
    done_seen = 0;
    dump_start = 1'b1;
    cycle();
    dump_start = 1'b0;
    wait_addr(4);
    dump_ready = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'hBEEF;
    cycle();
    wr_en = 1'b0;
    check("stall_live_data", 32'(dump_data), 32'hBEEF);
    dump_ready = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'hCAFE;
    check("collision_beat", 32'(dump_data), 32'hBEEF);
    cycle();
    wr_en = 1'b0;
    check("collision_r4", 32'(r[4]), 32'hCAFE);
    check("collision_next", 32'(dump_addr), 32'd5);
    wait_addr(7);
    dump_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("stall_addr7", 32'(dump_addr), 32'd7);
      check("stall_data7", 32'(dump_data), 32'hA007);
    end
    dump_ready = 1'b1;
    cycle();
    check("resume_addr8", 32'(dump_addr), 32'd8);
    wait_addr(9);
    dump_start = 1'b1;
    cycle();
    dump_start = 1'b0;
    check("start_ignored", 32'(dump_addr), 32'd10);
    wait_addr(12);
    mid_reset();
    repeat (3) cycle();
    check("no_done_after_reset", 32'(done_seen), 32'd0);
    dump_start = 1'b1;
    cycle();
    dump_start = 1'b0;
    check("restart_addr0", 32'(dump_addr), 32'd0);
    check("restart_valid", 32'(dump_valid), 32'd1);

    // Random traffic: writes, dump requests and ready jitter
    for (int k = 0; k < 300; k++) begin
      wr_en      = 1'($urandom_range(0, 1));
      wr_addr    = 4'($urandom_range(0, 15));
      wr_data    = 16'($urandom);
      dump_ready = ($urandom_range(0, 3) != 0);
      dump_start = ($urandom_range(0, 7) == 0);
      cycle();
    end
    wr_en = 1'b0; dump_start = 1'b0; dump_ready = 1'b1;
    n = 0;
    while (phase != 0 && n < 40) begin
      cycle();
      n++;
    end
    check("drain_idle", 32'(dump_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
# reg_bank

- Sixteen-entry, 16-bit general-purpose register storage for the datapath.
- Holds r0–r15 and drives them in parallel to the operand-select muxes directly downstream, which pick A/B operands by 4-bit register index.
- Accepts one synchronous write per cycle from write-back.
- Includes a handshaked debug dump engine that walks all sixteen registers out a single port, for board bring-up and bench checking.

## Interface

Parameters:
- WIDTH, 16, data width of every register and of the write/dump data.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- wr_en  in  1  write strobe from write-back.
- wr_addr  in  4  destination register index.
- wr_data  in  WIDTH  value to write.
- r0 … r15  out  WIDTH each  current register contents, registered outputs, no combinational path from inputs.
- dump_start  in  1  request a full register dump.
- dump_busy  out  1  high from dump acceptance until the DONE cycle completes.
- dump_valid  out  1  dump_addr/dump_data hold a valid beat.
- dump_ready  in  1  consumer accepts the beat when valid and ready are both high.
- dump_addr  out  4  index of the register being presented.
- dump_data  out  WIDTH  contents of register dump_addr.
- dump_done  out  1  one-cycle pulse after the final beat is accepted.

## Operation

- **Write:** on a clk edge with wr_en=1, reg[wr_addr] <= wr_data. With wr_en=0, nothing changes. The new value appears on rN the cycle after the edge.
- **Dump FSM states:** IDLE, SEND, DONE.
  - IDLE: dump_busy=0, dump_valid=0. dump_start=1 moves to SEND and sets cnt=0.
  - SEND: dump_busy=1, dump_valid=1, dump_addr=cnt, dump_data=reg[cnt] (live value, combinational from cnt).
    - Beat accepted with cnt<15: cnt+1.
    - Beat accepted with cnt=15: go to DONE.
    - Beat not accepted: hold cnt and stay in SEND; dump_data tracks any write to reg[cnt].
  - DONE: dump_done=1, dump_busy=1, dump_valid=0 for exactly one cycle, then IDLE.
- dump_start while in SEND or DONE is ignored; no queuing.
- Writes proceed unaffected during a dump.
  - If a write to reg[cnt] lands on the same edge as the beat transfer, the transferred dump_data is the old value.
- cnt is 4 bits. The SEND→DONE transition at 15 prevents wrap-around to 0.

## Timing

- Reset values: r0–r15=0, FSM=IDLE, cnt=0, dump_busy=0, dump_valid=0, dump_done=0, dump_addr=0, dump_data=reg[0]=0.
- Write latency: 1 cycle, from the wr_en edge to rN update.
- Dump start latency: dump_valid rises the cycle after dump_start is sampled in IDLE.
- Minimum dump length: 16 SEND cycles + 1 DONE cycle = 17 cycles with ready held high.
- Asynchronous reset mid-dump: FSM returns to IDLE immediately and all registers clear. No dump_done pulse is produced.
- Outputs r0–r15 change only on clk edges or on reset assertion.

## Configuration

- REG_BANK_R0_ZERO_EN defined:
  - r0 is hardwired to 0.
  - Writes with wr_addr=0 are discarded.
  - The dump beat for address 0 always carries 0.
- REG_BANK_R0_ZERO_EN undefined: r0 is an ordinary writable register, identical to r1–r15.

## Test plan

- **Reset:** assert reset mid-cycle with r5=16'h1234 → all rN=0 and dump_busy=0 without waiting for an edge.
- **Write all:** write reg[i]=16'hA000+i for i=0..15 → each rN equals its value one cycle after its write; other registers are unchanged. Under REG_BANK_R0_ZERO_EN, r0 stays 0.
- **Full dump, ready held high:** with the preloaded values, pulse dump_start → 16 consecutive beats, addr 0..15 with data 16'hA000..16'hA00F (beat 0 = 0 under the macro). dump_done pulses on cycle 17; busy then drops.
- **Backpressure:** drop dump_ready for 3 cycles at addr 7 → addr 7 and its data are held stable. Resume → addr 8 next, with no beat lost or duplicated.
- **Write collision:** while stalled at addr 4, write 16'hBEEF to reg 4 → dump_data shows 16'hBEEF the next cycle.
  - Then write 16'hCAFE on the same edge as the accepting handshake → the transferred beat is 16'hBEEF and r4 becomes 16'hCAFE.
- **Start during busy and reset mid-dump:** pulse dump_start at addr 9 → ignored, sequence continues. Assert reset at addr 12 → IDLE, no dump_done. A new dump_start afterwards begins at addr 0.
